// File: rtl/mem_map_pkg.sv
// Shared address map and byte width for the MemCtrl RAM bus responder.
//
// Contents:
//   BYTE_W          - bus data width (bytes)
//   IO_SEL          - value of addr[17:16] that selects the IO window
//   IO_DATA_ADDR    - TX push (write) / RX pop (read) register
//   IO_FINISH_ADDR  - finish latch (write) / optional status (read)
//   io_reg_e        - decoded IO register inside the window
//   decode_io()     - maps an 18-bit bus address to io_reg_e
package mem_map_pkg;

    localparam int          BYTE_W         = 8;
    localparam logic [1:0]  IO_SEL         = 2'b11;
    localparam logic [17:0] IO_DATA_ADDR   = 18'h30000;
    localparam logic [17:0] IO_FINISH_ADDR = 18'h30004;

    typedef enum logic [1:0] {
        IO_REG_DATA,
        IO_REG_FINISH,
        IO_REG_OTHER
    } io_reg_e;

    // Only meaningful when addr[17:16] == IO_SEL; callers check that first.
    function automatic io_reg_e decode_io(input logic [17:0] addr);
        if (addr == IO_DATA_ADDR) begin
            return IO_REG_DATA;
        end else if (addr == IO_FINISH_ADDR) begin
            return IO_REG_FINISH;
        end else begin
            return IO_REG_OTHER;
        end
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO used for both the TX (bus -> host) and the
// RX (host -> bus) paths.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset (empties the FIFO)
//   push, din - write request and byte; ignored when full unless a pop
//               happens in the same cycle
//   pop       - read request; ignored when empty
//   dout      - head byte, forced to 0 when empty so readers of an empty
//               FIFO see a deterministic 0x00
//   count     - occupancy, 0..DEPTH
//   full      - count == DEPTH
//   empty     - count == 0
//
// Parameter DEPTH must be a power of two so the pointers wrap naturally.
module byte_fifo
    import mem_map_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [BYTE_W-1:0]        din,
    output logic [BYTE_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rd_ptr];

    // A push into a full FIFO is only safe when the head leaves in the same
    // cycle; the slot being written is then the one being vacated.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Byte-serial responder at the far end of the MemCtrl RAM bus. Every clock
// is a transaction: mem_a/mem_wr/mem_dout are sampled each edge and the
// read result appears on mem_din one cycle later. Addresses with
// addr[17:16] == 2'b11 go to the IO window instead of RAM.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   mem_a[31:0]       - byte address (only [17:0] decoded)
//   mem_wr            - 1 = write, 0 = read
//   mem_dout[7:0]     - write data from controller
//   mem_din[7:0]      - registered read data to controller
//   io_buffer_full    - registered TX near-full flag for store throttling
//   tx_valid/tx_data  - TX FIFO head toward the host
//   tx_ready          - host consumes TX head
//   rx_valid/rx_data  - byte offered by the host
//   rx_ready          - RX FIFO has room
//   program_finished  - sticky, set by a write to the finish register
//
// Host handshakes: a byte moves on a rising edge where valid and ready are
// both high; valid is never withdrawn by this block once raised, and ready
// depends only on FIFO occupancy, never on valid.
//
// Build option: define MEM_BUS_STATUS_REG_EN to make a read of the finish
// register return {6'b0, rx_nonempty, tx_full}; otherwise it reads 0x00.
module mem_bus_responder
    import mem_map_pkg::*;
#(
    parameter int ADDR_W   = 17,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_a,
    input  logic              mem_wr,
    input  logic [BYTE_W-1:0] mem_dout,
    output logic [BYTE_W-1:0] mem_din,
    output logic              io_buffer_full,
    output logic              tx_valid,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              program_finished
);

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    // Two entries of headroom: one store may already be on the bus when the
    // controller sees the flag.
    localparam logic [TX_CW-1:0] IBF_LEVEL = TX_CW'(TX_DEPTH - 2);

    logic [17:0]       addr;
    logic              io_hit;
    io_reg_e           io_reg;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;

    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [BYTE_W-1:0] tx_dout;
    logic [TX_CW-1:0]  tx_count;

    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [BYTE_W-1:0] rx_dout;
    logic [RX_CW-1:0]  rx_count;

    logic [BYTE_W-1:0] ram [2**ADDR_W];
    logic [BYTE_W-1:0] din_next;
    logic              unused_sink;

    assign addr     = mem_a[17:0];
    assign io_hit   = (addr[17:16] == IO_SEL);
    assign io_reg   = decode_io(addr);
    assign ram_addr = mem_a[ADDR_W-1:0];
    assign ram_we   = !io_hit && mem_wr;

    assign tx_push  = io_hit && mem_wr && (io_reg == IO_REG_DATA);
    assign tx_pop   = tx_valid && tx_ready;
    assign rx_pop   = io_hit && !mem_wr && (io_reg == IO_REG_DATA);
    assign rx_push  = rx_valid && rx_ready;

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_dout;
    assign rx_ready = !rx_full;

    assign unused_sink = ^{mem_a[31:18], rx_count, rx_empty, tx_full};

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (mem_dout),
        .dout  (tx_dout),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_dout),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // RAM is read on every non-IO cycle, including writes, so a write
    // returns the byte it overwrites.
    always_comb begin
        din_next = '0;
        if (!io_hit) begin
            din_next = ram[ram_addr];
        end else if (!mem_wr) begin
            case (io_reg)
                IO_REG_DATA: din_next = rx_dout;
                IO_REG_FINISH: begin
`ifdef MEM_BUS_STATUS_REG_EN
                    din_next = {6'b0, !rx_empty, tx_full};
`else
                    din_next = '0;
`endif
                end
                default: din_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr] <= mem_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_din          <= '0;
            io_buffer_full   <= 1'b0;
            program_finished <= 1'b0;
        end else begin
            mem_din        <= din_next;
            io_buffer_full <= (tx_count >= IBF_LEVEL);
            if (io_hit && mem_wr && (io_reg == IO_REG_FINISH)) begin
                program_finished <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_a = '0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = '0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready;
    logic        program_finished;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];

    logic chk_now = 1'b0;
    logic chk_d   = 1'b0;

    logic [7:0] status_exp;

    mem_bus_responder dut (
        .clk              (clk),
        .rst              (rst),
        .mem_a            (mem_a),
        .mem_wr           (mem_wr),
        .mem_dout         (mem_dout),
        .mem_din          (mem_din),
        .io_buffer_full   (io_buffer_full),
        .tx_valid         (tx_valid),
        .tx_data          (tx_data),
        .tx_ready         (tx_ready),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_ready         (rx_ready),
        .program_finished (program_finished)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: read data one cycle after a checked read, and each
    // TX byte the host takes
    always @(posedge clk) chk_d <= chk_now;

    always @(negedge clk) begin
        if (chk_d) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL mem_din: got 0x%0h, expected no checked read", mem_din);
            end else begin
                check("mem_din", {24'b0, mem_din}, {24'b0, exp_q.pop_front()});
            end
        end
        if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                n_total++;
                $display("FAIL tx_data: got 0x%0h, expected no TX byte", tx_data);
            end else begin
                check("tx_data", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
            end
        end
    end

    // driver tasks: each call occupies one bus cycle; signals assigned
    // right after a call returns are sampled on the same edge as that call
    task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d,
                       input logic chk, input logic [7:0] exp);
        @(posedge clk);
        #1;
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
        chk_now  = chk;
        if (chk) exp_q.push_back(exp);
    endtask

    task automatic idle();
        bus(32'h0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        bus(a, 1'b1, d, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] exp);
        bus(a, 1'b0, 8'h00, 1'b1, exp);
    endtask

    task automatic rx_fill(input int n, input logic [7:0] base);
        idle();
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = base + 8'(i);
            idle();
        end
        rx_valid = 1'b0;
    endtask

    initial begin : stimulus
        logic [7:0] t2 [4];
        t2[0] = 8'h78; t2[1] = 8'h56; t2[2] = 8'h34; t2[3] = 8'h12;

        // reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_din", {24'b0, mem_din}, 32'h0);
        check("rst_ibf", {31'b0, io_buffer_full}, 32'h0);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'b0, tx_data}, 32'h0);
        check("rst_rx_ready", {31'b0, rx_ready}, 32'h1);
        check("rst_finished", {31'b0, program_finished}, 32'h0);

        // RAM write then read; write returns the old byte
        wr(32'h10, 8'hAB);
        rd(32'h10, 8'hAB);
        bus(32'h10, 1'b1, 8'h55, 1'b1, 8'hAB);
        rd(32'h10, 8'h55);

        for (int i = 0; i < 4; i++) wr(32'h100 + i, t2[i]);
        for (int i = 0; i < 4; i++) rd(32'h100 + i, t2[i]);

        // TX push does not touch RAM alias 0x10000
        wr(32'h10000, 8'h99);
        wr(32'h30000, 8'h41);
        tx_q.push_back(8'h41);
        rd(32'h10000, 8'h99);
        idle();
        @(negedge clk);
        check("tx_valid_after_push", {31'b0, tx_valid}, 32'h1);
        check("tx_head", {24'b0, tx_data}, 32'h41);
        idle();
        tx_ready = 1'b1;
        idle();
        tx_ready = 1'b0;
        @(negedge clk);
        check("tx_valid_after_pop", {31'b0, tx_valid}, 32'h0);

        // unmapped IO offsets
        rd(32'h30008, 8'h00);
        wr(32'h30008, 8'h33);
        status_exp = 8'h00;
        rd(32'h30004, status_exp);
        idle();
        idle();
        @(negedge clk);
        check("io_other_no_tx", {31'b0, tx_valid}, 32'h0);
        check("io_other_no_finish", {31'b0, program_finished}, 32'h0);
        rd(32'h30008 & 32'h1FFFF, 8'h00);

        // TX near-full threshold
        for (int i = 0; i < 13; i++) begin
            wr(32'h30000, 8'h60 + 8'(i));
            tx_q.push_back(8'h60 + 8'(i));
        end
        idle();
        idle();
        @(negedge clk);
        check("ibf_at_13", {31'b0, io_buffer_full}, 32'h0);
        wr(32'h30000, 8'h6D);
        tx_q.push_back(8'h6D);
        idle();
        @(negedge clk);
        check("ibf_registered_delay", {31'b0, io_buffer_full}, 32'h0);
        @(negedge clk);
        check("ibf_at_14", {31'b0, io_buffer_full}, 32'h1);

        // fill to 16, drop the 17th, then push while full with a pop
        wr(32'h30000, 8'h6E);
        tx_q.push_back(8'h6E);
        wr(32'h30000, 8'h6F);
        tx_q.push_back(8'h6F);
        wr(32'h30000, 8'h70);
        idle();
`ifdef MEM_BUS_STATUS_REG_EN
        status_exp = 8'h01;
`else
        status_exp = 8'h00;
`endif
        rd(32'h30004, status_exp);
        wr(32'h30000, 8'hEE);
        tx_ready = 1'b1;
        tx_q.push_back(8'hEE);
        idle();
        tx_ready = 1'b0;
        idle();
        tx_ready = 1'b1;
        repeat (20) idle();
        tx_ready = 1'b0;
        @(negedge clk);
        check("tx_drain_left", tx_q.size(), 32'h0);
        check("tx_valid_drained", {31'b0, tx_valid}, 32'h0);
        check("ibf_drained", {31'b0, io_buffer_full}, 32'h0);

        // RX pop, pop of empty, empty pop with simultaneous push
        idle();
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        idle();
        rx_valid = 1'b0;
        rd(32'h30000, 8'h5A);
        idle();
        rd(32'h30000, 8'h00);
        idle();
        rd(32'h30000, 8'h00);
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        idle();
        rx_valid = 1'b0;
        rd(32'h30000, 8'h77);
        idle();

        // RX full boundary
        rx_fill(16, 8'hC0);
        @(negedge clk);
        check("rx_ready_full", {31'b0, rx_ready}, 32'h0);
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        idle();
        rx_valid = 1'b0;
`ifdef MEM_BUS_STATUS_REG_EN
        status_exp = 8'h02;
`else
        status_exp = 8'h00;
`endif
        rd(32'h30004, status_exp);
        for (int i = 0; i < 16; i++) begin
            rd(32'h30000, 8'hC0 + 8'(i));
            idle();
        end
        rd(32'h30000, 8'h00);
        idle();

        // finish latch, then reset with both FIFOs holding data
        wr(32'h30004, 8'h5C);
        idle();
        @(negedge clk);
        check("finished_set", {31'b0, program_finished}, 32'h1);
        rx_fill(16, 8'h20);
        for (int i = 0; i < 15; i++) wr(32'h30000, 8'h80 + 8'(i));
        idle();
        idle();
        @(negedge clk);
        check("finished_sticky", {31'b0, program_finished}, 32'h1);
        check("pre_rst_ibf", {31'b0, io_buffer_full}, 32'h1);
        check("pre_rst_rx_ready", {31'b0, rx_ready}, 32'h0);
        idle();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_finished", {31'b0, program_finished}, 32'h0);
        check("mid_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("mid_rst_tx_data", {24'b0, tx_data}, 32'h0);
        check("mid_rst_ibf", {31'b0, io_buffer_full}, 32'h0);
        check("mid_rst_rx_ready", {31'b0, rx_ready}, 32'h1);
        rd(32'h30000, 8'h00);
        idle();
        rd(32'h10, 8'h55);
        repeat (3) idle();
        @(negedge clk);
        check("read_queue_drained", exp_q.size(), 32'h0);

        // report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Byte-serial memory/IO responder at the far end of the MemCtrl RAM bus (mem_a / mem_wr / mem_dout in, mem_din out).
- Holds the unified instruction/data RAM and decodes the IO window (addr[17:16]==2'b11) into a TX byte FIFO toward the host UART, an RX byte FIFO from the host, and a finish latch.
- Drives io_buffer_full back to the controller so it can throttle IO stores.

Parameters:
- ADDR_W, 17, RAM byte-address width; RAM depth is 2^ADDR_W bytes.
- TX_DEPTH, 16, TX FIFO entries (power of two, >=4).
- RX_DEPTH, 16, RX FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mem_a  in  32  byte address from controller; only [17:0] decoded
- mem_wr  in  1  1 = write, 0 = read
- mem_dout  in  8  write data from controller
- mem_din  out  8  registered read data to controller
- io_buffer_full  out  1  TX FIFO near-full, to controller
- tx_valid  out  1  TX FIFO head valid
- tx_data  out  8  TX FIFO head byte
- tx_ready  in  1  host consumes TX head
- rx_valid  in  1  host offers RX byte
- rx_data  in  8  RX byte
- rx_ready  out  1  RX FIFO not full
- program_finished  out  1  sticky finish flag

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: mem_din=0, io_buffer_full=0, tx_valid=0, tx_data=0, rx_ready=1, program_finished=0, both FIFOs emptied. RAM contents are not reset. A reset mid-operation discards all FIFO contents immediately.
- Every cycle is a transaction; there is no request/valid signal. Idle cycles from the controller present mem_a=0 with mem_wr=0, which is a harmless RAM read.
- RAM read (IO bit clear, mem_wr=0): mem_din at t+1 = RAM[mem_a[ADDR_W-1:0]] sampled at t. Latency is exactly 1 cycle.
- RAM write (IO bit clear, mem_wr=1): RAM[a] <= mem_dout at the edge. mem_din at t+1 is don't-care but must be deterministic: the old byte (read-before-write).
- IO writes never modify RAM. IO reads never read RAM.
- IO map:
  - 0x30000 write: push mem_dout into the TX FIFO. If the FIFO is full, the byte is dropped.
  - 0x30000 read: pop the RX FIFO; mem_din at t+1 = popped byte, or 0x00 if the FIFO was empty.
  - 0x30004 write: program_finished <= 1; it stays set until rst.
  - 0x30004 read: see the optional feature.
  - Any other IO offset: writes ignored, reads return 0x00.
- Pop side effect: one pop per cycle in which a 0x30000 read is presented. The controller guarantees no back-to-back IO reads of the same access.
- io_buffer_full is registered: 1 when tx_count >= TX_DEPTH-2, updated one cycle after the count changes. The 2-entry margin absorbs one in-flight store.
- TX FIFO:
  - tx_valid = count != 0; tx_data = head byte.
  - A pop occurs when tx_valid && tx_ready.
  - Simultaneous push and pop: both take effect and the count is unchanged. When full, the push is accepted only if a pop occurs in the same cycle.
- RX FIFO:
  - rx_ready = count != RX_DEPTH.
  - A push occurs when rx_valid && rx_ready.
  - Simultaneous host push and bus pop: both take effect. A bus pop of an empty FIFO combined with a push in the same cycle returns 0x00 and the pushed byte is retained.
- Pointers are log2(depth) bits wide; the count is log2(depth)+1 bits; pointers wrap modulo depth.

Optional Feature:
- Macro: MEM_BUS_STATUS_REG_EN.
- Defined: a 0x30004 read returns {6'b0, rx_nonempty, tx_full_now} at t+1, with no side effects.
- Undefined: a 0x30004 read returns 0x00. Write behaviour is unchanged in both cases.

Decomposition:
- Shared package mem_map_pkg:
  - IO_SEL (2'b11 at [17:16])
  - IO_DATA_ADDR = 18'h30000, IO_FINISH_ADDR = 18'h30004
  - BYTE_W = 8
- One sub-module, byte_fifo (parameter DEPTH), instantiated twice for TX and RX. It exposes push/pop/din/dout/count/full/empty.

Test Plan:
- Write 0xAB to 0x00010, then read 0x00010 on the next cycle -> mem_din == 0xAB exactly one cycle after the read address.
- Write 0x78, 0x56, 0x34, 0x12 to 0x100..0x103 on consecutive cycles, then read 0x100..0x103 -> mem_din returns 0x78, 0x56, 0x34, 0x12 at t+1 each.
- With tx_ready=0, write 0x41 to 0x30000 -> tx_valid=1, tx_data=0x41 the next cycle; a later RAM read of 0x10000 is unaffected. Raise tx_ready for one cycle -> tx_valid=0.
- With tx_ready=0, push TX_DEPTH-2 = 14 bytes -> io_buffer_full=1 one cycle after the 14th push. Push 3 more -> the 17th is dropped and the FIFO drains exactly 16 bytes.
- Host pushes 0x5A on RX, then read 0x30000 -> mem_din=0x5A at t+1. A second read two cycles later -> mem_din=0x00.
- Write any byte to 0x30004 -> program_finished=1 and sticky. Assert rst while both FIFOs hold data -> next cycle program_finished=0, tx_valid=0, io_buffer_full=0, rx_ready=1.
